// File: rtl/gauss_kernel_gen_if.sv
// Request/result bundle for gauss_kernel_gen; the generator sits on the slave side.
// The row-stream signals exist only when GAUSS_ROW_STREAM_EN is defined.
interface gauss_kernel_gen_if #(
    parameter int MAX_KERNEL = 7,
    parameter int COEF_W     = 16,
    parameter int SUM_W      = 32
);
    localparam int KS_W = $clog2(MAX_KERNEL + 1);
    localparam int RI_W = $clog2(MAX_KERNEL);

    logic                                   start;
    logic                                   mode;
    logic [KS_W-1:0]                        kernel_size;
    logic                                   busy;
    logic                                   done;
    logic                                   err;
    logic [MAX_KERNEL*MAX_KERNEL*COEF_W-1:0] kernel;
    logic [SUM_W-1:0]                       sum;
    logic [4:0]                             norm_shift;
    logic                                   pow2;
`ifdef GAUSS_ROW_STREAM_EN
    logic                                   row_valid;
    logic [RI_W-1:0]                        row_idx;
    logic [MAX_KERNEL*COEF_W-1:0]           row_data;

    modport master (output start, mode, kernel_size,
                    input  busy, done, err, kernel, sum, norm_shift, pow2,
                           row_valid, row_idx, row_data);
    modport slave  (input  start, mode, kernel_size,
                    output busy, done, err, kernel, sum, norm_shift, pow2,
                           row_valid, row_idx, row_data);
`else
    modport master (output start, mode, kernel_size,
                    input  busy, done, err, kernel, sum, norm_shift, pow2);
    modport slave  (input  start, mode, kernel_size,
                    output busy, done, err, kernel, sum, norm_shift, pow2);
`endif
endinterface

// File: rtl/gauss_kernel_gen.sv
// Integer 2-D smoothing kernel generator: binomial (GAUSS) or all-ones (BOX), odd side k.
// Optional row streaming of the outer-product phase is enabled by defining GAUSS_ROW_STREAM_EN.
module gauss_kernel_gen #(
    parameter int MAX_KERNEL = 7,
    parameter int COEF_W     = 16,
    parameter int SUM_W      = 32
) (
    input logic               clk,
    input logic               rst,
    gauss_kernel_gen_if.slave bus
);
    localparam int KS_W  = $clog2(MAX_KERNEL + 1);
    localparam int RI_W  = $clog2(MAX_KERNEL);
    localparam int ACC_W = ((SUM_W > COEF_W + 4) ? SUM_W : COEF_W + 4) + 1;
    localparam logic [KS_W-1:0] MAX_K = KS_W'(MAX_KERNEL);

    typedef enum logic [1:0] {IDLE, PASCAL, OUTER, FIN} state_t;

    state_t                                         state_q, state_d;
    logic                                           mode_q, mode_d;
    logic [KS_W-1:0]                                k_q, k_d;
    logic [KS_W-1:0]                                cnt_q, cnt_d;
    logic [MAX_KERNEL-1:0][COEF_W-1:0]              w_q, w_d;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][COEF_W-1:0] kern_q, kern_d;
    logic [SUM_W-1:0]                               sum_q, sum_d;
    logic [4:0]                                     ns_q, ns_d;
    logic                                           pow2_q, pow2_d;
    logic                                           err_q, err_d;
    logic                                           busy_q, busy_d;
    logic                                           done_q, done_d;
    logic [MAX_KERNEL-1:0][COEF_W-1:0]              row_s;
    logic [ACC_W-1:0]                               row_tot_s;
    logic [ACC_W-1:0]                               acc_s;
    logic [SUM_W-1:0]                               sum_sat_s;
    logic                                           bad_k_s;

    function automatic logic [COEF_W-1:0] mul_sat(input logic [COEF_W-1:0] a,
                                                  input logic [COEF_W-1:0] b);
        logic [2*COEF_W-1:0] p;
        p = {{COEF_W{1'b0}}, a} * {{COEF_W{1'b0}}, b};
        if (|p[2*COEF_W-1:COEF_W]) mul_sat = {COEF_W{1'b1}};
        else                       mul_sat = p[COEF_W-1:0];
    endfunction

    function automatic logic [COEF_W-1:0] add_sat(input logic [COEF_W-1:0] a,
                                                  input logic [COEF_W-1:0] b);
        logic [COEF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[COEF_W]) add_sat = {COEF_W{1'b1}};
        else           add_sat = s[COEF_W-1:0];
    endfunction

    function automatic logic is_pow2(input logic [SUM_W-1:0] v);
        is_pow2 = (v != '0) && ((v & (v - SUM_W'(1))) == '0);
    endfunction

    function automatic logic [4:0] log2_of(input logic [SUM_W-1:0] v);
        log2_of = 5'd0;
        for (int b = 0; b < SUM_W; b++) begin
            if (v[b]) log2_of = 5'(b);
            else      log2_of = log2_of;
        end
    endfunction

    // Products of the row addressed by cnt_q (zero outside k and for an invalid k) and their total
    always_comb begin
        row_s     = '0;
        row_tot_s = '0;
        for (int c = 0; c < MAX_KERNEL; c++) begin
            if (!err_q && (KS_W'(c) < k_q)) row_s[c] = mul_sat(w_q[cnt_q], w_q[c]);
            else                            row_s[c] = '0;
            row_tot_s = row_tot_s + ACC_W'(row_s[c]);
        end
        acc_s = ACC_W'(sum_q) + row_tot_s;
        if (acc_s > ACC_W'({SUM_W{1'b1}})) sum_sat_s = {SUM_W{1'b1}};
        else                               sum_sat_s = acc_s[SUM_W-1:0];
        bad_k_s = (bus.kernel_size == '0) || !bus.kernel_size[0] || (bus.kernel_size > MAX_K);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        kern_d  = kern_q;
        sum_d   = sum_q;
        ns_d    = ns_q;
        pow2_d  = pow2_q;
        err_d   = err_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    k_d     = bus.kernel_size;
                    cnt_d   = '0;
                    w_d     = '0;
                    w_d[0]  = COEF_W'(1);
                    kern_d  = '0;
                    sum_d   = '0;
                    ns_d    = 5'd0;
                    pow2_d  = 1'b0;
                    err_d   = bad_k_s;
                    busy_d  = 1'b1;
                    // An invalid k spends one write-suppressed OUTER cycle so done lands after E+1
                    if (bad_k_s || (bus.kernel_size == KS_W'(1))) state_d = OUTER;
                    else                                          state_d = PASCAL;
                end else begin
                    state_d = IDLE;
                end
            end
            PASCAL: begin
                busy_d = 1'b1;
                for (int i = 1; i < MAX_KERNEL; i++) begin
                    if (mode_q) w_d[i] = (KS_W'(i) < k_q) ? COEF_W'(1) : COEF_W'(0);
                    else        w_d[i] = add_sat(w_q[i], w_q[i-1]);
                end
                if (cnt_q == (k_q - KS_W'(2))) begin
                    cnt_d   = '0;
                    state_d = OUTER;
                end else begin
                    cnt_d   = cnt_q + KS_W'(1);
                end
            end
            OUTER: begin
                kern_d[cnt_q] = row_s;
                sum_d         = sum_sat_s;
                if (err_q || (cnt_q == (k_q - KS_W'(1)))) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    pow2_d  = is_pow2(sum_sat_s);
                    if (is_pow2(sum_sat_s)) ns_d = log2_of(sum_sat_s);
                    else                    ns_d = 5'd0;
                end else begin
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + KS_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any run in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            k_q     <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            kern_q  <= '0;
            sum_q   <= '0;
            ns_q    <= 5'd0;
            pow2_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            kern_q  <= kern_d;
            sum_q   <= sum_d;
            ns_q    <= ns_d;
            pow2_q  <= pow2_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.kernel     = kern_q;
    assign bus.sum        = sum_q;
    assign bus.norm_shift = ns_q;
    assign bus.pow2       = pow2_q;

`ifdef GAUSS_ROW_STREAM_EN
    logic row_valid_s;
    assign row_valid_s   = (state_q == OUTER) && !err_q;
    assign bus.row_valid = row_valid_s;
    assign bus.row_idx   = row_valid_s ? cnt_q[RI_W-1:0] : '0;
    assign bus.row_data  = row_valid_s ? row_s : '0;
`endif
endmodule

// File: tb/tb_gauss_kernel_gen.sv
// Directed bench for gauss_kernel_gen with hand-computed kernels, sums and latencies.
module tb_gauss_kernel_gen;
    localparam int MK   = 7;
    localparam int CW   = 16;
    localparam int SW   = 32;
    localparam int KS_W = $clog2(MK + 1);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int               lat_r;
    int               busy_r;
    int               rows_r;
    int               row_idx_log [MK];
    logic [MK*CW-1:0] row_log [MK];
    int               exp_w [MK];

    gauss_kernel_gen_if #(.MAX_KERNEL(MK), .COEF_W(CW), .SUM_W(SW)) bus ();

    gauss_kernel_gen #(.MAX_KERNEL(MK), .COEF_W(CW), .SUM_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int coef(input int r, input int c);
        logic [MK*MK*CW-1:0] kv;
        kv   = bus.kernel;
        coef = int'(kv[(r*MK+c)*CW +: CW]);
    endfunction

    // Hand-written 1-D rows; an invalid k leaves the row all zero
    task automatic set_row(input logic m, input int k);
        for (int i = 0; i < MK; i++) exp_w[i] = 0;
        if (m && (k == 1 || k == 3 || k == 5 || k == 7)) begin
            for (int i = 0; i < k; i++) exp_w[i] = 1;
        end else if (!m) begin
            case (k)
                1: exp_w[0] = 1;
                3: begin exp_w[0] = 1; exp_w[1] = 2; exp_w[2] = 1; end
                5: begin exp_w[0] = 1; exp_w[1] = 4; exp_w[2] = 6; exp_w[3] = 4; exp_w[4] = 1; end
                7: begin exp_w[0] = 1; exp_w[1] = 6; exp_w[2] = 15; exp_w[3] = 20;
                         exp_w[4] = 15; exp_w[5] = 6; exp_w[6] = 1; end
                default: exp_w[0] = 0;
            endcase
        end
    endtask

    task automatic run(input logic m, input int k, input int poke, input bit fin_poke);
        int n;
        bit seen;
        lat_r = -1; busy_r = 0; rows_r = 0; seen = 1'b0; n = 0;
        for (int i = 0; i < MK; i++) begin row_log[i] = '0; row_idx_log[i] = -1; end
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.kernel_size = KS_W'(k);
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done) begin
                seen  = 1'b1;
                lat_r = n - 1;
                check_eq("busy_at_done", bus.busy, 0);
`ifdef GAUSS_ROW_STREAM_EN
                check_eq("row_valid_at_done", bus.row_valid, 0);
                check_eq("row_data_at_done", 64'(bus.row_data != '0), 0);
`endif
                if (fin_poke) begin
                    bus.start = 1'b1; bus.kernel_size = KS_W'(5);
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                end
            end else begin
                if (bus.busy) busy_r++;
`ifdef GAUSS_ROW_STREAM_EN
                if (bus.row_valid) begin
                    if (rows_r < MK) begin
                        row_idx_log[rows_r] = int'(bus.row_idx);
                        row_log[rows_r]     = bus.row_data;
                    end
                    rows_r++;
                end
`endif
                if (n == poke) begin
                    bus.start = 1'b1; bus.mode = ~m; bus.kernel_size = KS_W'(5);
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                end
            end
        end
        check_eq("done_seen", 64'(seen), 1);
        @(negedge clk);
        check_eq("done_one_cycle", bus.done, 0);
    endtask

    task automatic check_result(input string tag, input logic m, input int k, input int elat,
                                input int esum, input int ens, input int ep2, input int eerr);
        int bad;
        set_row(m, k);
        bad = 0;
        for (int r = 0; r < MK; r++)
            for (int c = 0; c < MK; c++)
                if (coef(r, c) != exp_w[r] * exp_w[c]) bad++;
        check_eq({tag, "_latency"}, 64'(lat_r), 64'(elat));
        check_eq({tag, "_busy_cycles"}, 64'(busy_r), 64'(elat));
        check_eq({tag, "_kernel_bad_entries"}, 64'(bad), 0);
        check_eq({tag, "_sum"}, bus.sum, 64'(esum));
        check_eq({tag, "_norm_shift"}, bus.norm_shift, 64'(ens));
        check_eq({tag, "_pow2"}, bus.pow2, 64'(ep2));
        check_eq({tag, "_err"}, bus.err, 64'(eerr));
`ifdef GAUSS_ROW_STREAM_EN
        bad = 0;
        for (int r = 0; r < k && r < MK && eerr == 0; r++) begin
            if (row_idx_log[r] != r) bad++;
            for (int c = 0; c < MK; c++)
                if (int'(row_log[r][c*CW +: CW]) != exp_w[r] * exp_w[c]) bad++;
        end
        check_eq({tag, "_rows_streamed"}, 64'(rows_r), 64'((eerr != 0) ? 0 : k));
        check_eq({tag, "_row_stream_bad"}, 64'(bad), 0);
`endif
    endtask

    initial begin
        int dones;
        rst = 1'b1; bus.start = 1'b0; bus.mode = 1'b0; bus.kernel_size = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_sum", bus.sum, 0);
        check_eq("rst_pow2", bus.pow2, 0);
        check_eq("rst_norm_shift", bus.norm_shift, 0);
        check_eq("rst_kernel_nonzero", 64'(bus.kernel != '0), 0);
        rst = 1'b0;

        run(1'b0, 3, 0, 1'b0);
        check_result("g3", 1'b0, 3, 5, 16, 4, 1, 0);
        check_eq("g3_row0", 64'({coef(0,0), coef(0,1), coef(0,2)}), 64'({32'd1, 32'd2, 32'd1}));
        repeat (4) @(negedge clk);
        check_eq("g3_hold_sum", bus.sum, 16);
        check_eq("g3_hold_center", 64'(coef(1, 1)), 4);

        run(1'b0, 5, 0, 1'b0);
        check_result("g5", 1'b0, 5, 9, 256, 8, 1, 0);
        check_eq("g5_center", 64'(coef(2, 2)), 36);
        check_eq("g5_corner", 64'(coef(4, 4)), 1);
        check_eq("g5_edge_mid", 64'(coef(0, 2)), 6);

        run(1'b0, 7, 0, 1'b0);
        check_result("g7", 1'b0, 7, 13, 4096, 12, 1, 0);
        check_eq("g7_center", 64'(coef(3, 3)), 400);

        run(1'b0, 1, 0, 1'b0);
        check_result("g1", 1'b0, 1, 1, 1, 0, 1, 0);

        run(1'b1, 3, 0, 1'b0);
        check_result("b3", 1'b1, 3, 5, 9, 0, 0, 0);

        run(1'b0, 4, 0, 1'b0);
        check_result("k4", 1'b0, 4, 1, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        check_eq("k4_err_held", bus.err, 1);
        run(1'b0, 0, 0, 1'b0);
        check_result("k0", 1'b0, 0, 1, 0, 0, 0, 1);
        run(1'b1, 6, 0, 1'b0);
        check_result("k6", 1'b1, 6, 1, 0, 0, 0, 1);
        run(1'b0, 3, 0, 1'b0);
        check_result("after_err", 1'b0, 3, 5, 16, 4, 1, 0);

        // start pulsed in PASCAL with different mode/size must be ignored
        run(1'b0, 3, 1, 1'b0);
        check_result("poke", 1'b0, 3, 5, 16, 4, 1, 0);
        dones = 0;
        repeat (12) begin @(negedge clk); if (bus.done) dones++; end
        check_eq("poke_no_second_done", 64'(dones), 0);

        // start coincident with FIN must be ignored
        run(1'b0, 3, 0, 1'b1);
        check_eq("fin_start_busy", bus.busy, 0);
        check_eq("fin_start_sum", bus.sum, 16);

        // asynchronous reset in the middle of OUTER
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.kernel_size = KS_W'(3);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_outer_busy", bus.busy, 1);
        check_eq("mid_outer_partial_sum", bus.sum, 4);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_sum", bus.sum, 0);
        check_eq("abort_kernel_nonzero", 64'(bus.kernel != '0), 0);
`ifdef GAUSS_ROW_STREAM_EN
        check_eq("abort_row_valid", bus.row_valid, 0);
`endif
        @(negedge clk);
        check_eq("abort_no_done", bus.done, 0);
        rst = 1'b0;
        run(1'b0, 3, 0, 1'b0);
        check_result("post_rst", 1'b0, 3, 5, 16, 4, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
